// File: rtl/bus_pkg.sv
// Shared types and default sizing for the dValid/dAck bus transfer master.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bus_pkg;

    // Transfer FSM: wait for a word, hold it on the bus, then one idle recovery cycle.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        VALID   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_MAX_WAIT = 5;

endpackage

// File: rtl/bus_xfer_master_if.sv
// Local write port plus dValid/dAck bus and status signals of bus_xfer_master.
// Latency: n/a (wires only).
// Backpressure: wr_ready carries FIFO backpressure; dAck closes each bus word.
interface bus_xfer_master_if
    import bus_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              dValid;
    logic [DATA_W-1:0] data;
    logic              dAck;
    logic              xfer_done;
    logic              timeout_err;
    logic              proto_err;
    logic [LVL_W-1:0]  level;
    logic              busy;

    // The transfer master itself.
    modport master (
        input  wr_valid, wr_data, dAck,
        output wr_ready, dValid, data, xfer_done, timeout_err, proto_err, level, busy
    );

    // Producer / bus receiver side.
    modport slave (
        output wr_valid, wr_data, dAck,
        input  wr_ready, dValid, data, xfer_done, timeout_err, proto_err, level, busy
    );
endinterface

// File: rtl/bus_fifo.sv
// Synchronous FIFO, power-of-two depth, head word visible combinationally.
// Latency: a push is visible at the head one cycle later; no write bypass.
// Backpressure: push ignored when full, pop ignored when empty; full drives wr_ready.
module bus_fifo
    import bus_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              pop,
    output logic [DATA_W-1:0] head_dat,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              do_push, do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (level_q == LVL_W'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign head_dat = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        level_d  = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards any buffered words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end
endmodule

// File: rtl/bus_xfer_master.sv
// Buffers local words and drives each onto the dValid/dAck bus with a bounded wait; optional checker under BUS_PROTOCOL_CHECK_EN.
// Latency: push into empty FIFO in IDLE -> dValid one cycle later; ack -> dValid low + xfer_done next cycle; one recovery cycle between words.
// Backpressure: wr_ready = !full; a word stays on the bus until dAck or MAX_WAIT dValid-high cycles, then is dropped.
module bus_xfer_master
    import bus_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic               clk,
    input  logic               reset,
    bus_xfer_master_if.master  bif
);
    localparam int LVL_W  = $clog2(DEPTH + 1);
    localparam int WCNT_W = $clog2(MAX_WAIT + 1);

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              xfer_done_q, xfer_done_d;
    logic              timeout_err_q, timeout_err_d;

    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  fifo_level;
    logic              wait_last;
    logic              dvalid;

    bus_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (bif.wr_valid),
        .push_dat (bif.wr_data),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    assign wait_last       = (wait_cnt_q == WCNT_W'(MAX_WAIT));
    assign dvalid          = (state_q == VALID);
    assign bif.dValid      = dvalid;
    assign bif.data        = data_q;
    assign bif.xfer_done   = xfer_done_q;
    assign bif.timeout_err = timeout_err_q;
    assign bif.wr_ready    = !fifo_full;
    assign bif.level       = fifo_level;
    assign bif.busy        = !fifo_empty || (state_q != IDLE);

    // State and bus-side registers; reset drops the bus immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            data_q        <= '0;
            xfer_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            data_q        <= data_d;
            xfer_done_q   <= xfer_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next state: RECOVER sees the level after the pop, so it can chain straight into VALID.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = VALID;
            VALID:   if (bif.dAck || wait_last) state_d = RECOVER;
            RECOVER: state_d = fifo_empty ? IDLE : VALID;
            default: state_d = IDLE;
        endcase
    end

    // Per-state actions: load head on entry to VALID, zero data whenever dValid will be low.
    always_comb begin
        fifo_pop      = 1'b0;
        data_d        = data_q;
        wait_cnt_d    = wait_cnt_q;
        xfer_done_d   = 1'b0;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE, RECOVER: begin
                data_d = '0;
                if (!fifo_empty) begin
                    data_d     = fifo_head;
                    wait_cnt_d = WCNT_W'(1);
                end
            end
            VALID: begin
                if (bif.dAck) begin
                    fifo_pop    = 1'b1;
                    xfer_done_d = 1'b1;
                    data_d      = '0;
                end else if (wait_last) begin
                    fifo_pop      = 1'b1;
                    timeout_err_d = 1'b1;
                    data_d        = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            default: data_d = '0;
        endcase
    end

`ifdef BUS_PROTOCOL_CHECK_EN
    logic dack_prev_q, dack_prev_d;
    logic proto_err_q, proto_err_d;

    // Receiver-side rule check: ack without valid, or ack held across two cycles.
    always_comb begin
        dack_prev_d = bif.dAck;
        proto_err_d = proto_err_q
                    | (bif.dAck & ~dvalid)
                    | (bif.dAck & dack_prev_q);
    end

    // Sticky error flag and previous-ack history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dack_prev_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            dack_prev_q <= dack_prev_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign bif.proto_err = proto_err_q;

    a_data_stable: assert property (@(posedge clk) disable iff (!reset)
        dvalid |=> (!dvalid || $stable(bif.data)));

    a_recover_after_ack: assert property (@(posedge clk) disable iff (!reset)
        (dvalid && bif.dAck) |=> !dvalid);

    a_data_known: assert property (@(posedge clk) disable iff (!reset)
        dvalid |-> !$isunknown(bif.data));
`else
    assign bif.proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_xfer_master.sv
// Directed bench for bus_xfer_master: reset, ack timing, timeout boundary, full FIFO, push/pop, checker.
// Latency: n/a.
// Backpressure: n/a.
module tb_bus_xfer_master;
    import bus_pkg::*;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 5;

`ifdef BUS_PROTOCOL_CHECK_EN
    localparam logic PCHK = 1'b1;
`else
    localparam logic PCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bus_xfer_master_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bif ();

    bus_xfer_master #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bif   (bif.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        bif.wr_valid = 1'b1;
        bif.wr_data  = d;
        tick();
        bif.wr_valid = 1'b0;
    endtask

    // Called in VALID cycle 1; acks on cycle ack_n (out of range means never acked in time).
    task automatic run_word(input logic [7:0] exp_d, input int ack_n);
        bit done;
        logic exp_ack;
        done    = 1'b0;
        exp_ack = (ack_n >= 1) && (ack_n <= MAX_WAIT);
        for (int n = 1; n <= MAX_WAIT && !done; n++) begin
            chk("word_dvalid_hi", 32'(bif.dValid), 1);
            chk("word_data_hold", 32'(bif.data), 32'(exp_d));
            if (n == ack_n) begin
                bif.dAck = 1'b1;
                done     = 1'b1;
            end
            tick();
            bif.dAck = 1'b0;
        end
        chk("word_dvalid_lo", 32'(bif.dValid), 0);
        chk("word_data_zero", 32'(bif.data), 0);
        chk("word_xfer_done", 32'(bif.xfer_done), 32'(exp_ack));
        chk("word_timeout", 32'(bif.timeout_err), 32'(!exp_ack));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        bif.wr_valid = 1'b0;
        bif.wr_data  = '0;
        bif.dAck     = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_dvalid", 32'(bif.dValid), 0);
        chk("rst_data", 32'(bif.data), 0);
        chk("rst_xfer_done", 32'(bif.xfer_done), 0);
        chk("rst_timeout", 32'(bif.timeout_err), 0);
        chk("rst_proto", 32'(bif.proto_err), 0);
        chk("rst_level", 32'(bif.level), 0);
        chk("rst_busy", 32'(bif.busy), 0);
        chk("rst_wr_ready", 32'(bif.wr_ready), 1);
        reset = 1'b1;
        tick();

        // Single word, ack on VALID cycle 4
        push_word(8'hA5);
        chk("a5_level_after_push", 32'(bif.level), 1);
        chk("a5_no_bypass", 32'(bif.dValid), 0);
        chk("a5_busy", 32'(bif.busy), 1);
        tick();
        run_word(8'hA5, 4);
        chk("a5_level_after_ack", 32'(bif.level), 0);
        tick();
        chk("a5_xfer_done_once", 32'(bif.xfer_done), 0);
        chk("a5_idle_busy", 32'(bif.busy), 0);

        // Ack on the last allowed cycle
        push_word(8'h5A);
        tick();
        run_word(8'h5A, MAX_WAIT);
        tick();

        // Timeout: no ack through MAX_WAIT, late ack in the recovery cycle is ignored
        push_word(8'h3C);
        tick();
        run_word(8'h3C, 0);
        chk("to_level", 32'(bif.level), 0);
        bif.dAck = 1'b1;
        tick();
        bif.dAck = 1'b0;
        chk("to_late_ack_done", 32'(bif.xfer_done), 0);
        chk("to_late_ack_timeout", 32'(bif.timeout_err), 0);
        chk("to_late_ack_dvalid", 32'(bif.dValid), 0);
        chk("to_late_ack_busy", 32'(bif.busy), 0);
        chk("to_late_ack_proto", 32'(bif.proto_err), 32'(PCHK));

        // Reset while a word is on the bus
        push_word(8'h77);
        push_word(8'h88);
        chk("mid_pre_dvalid", 32'(bif.dValid), 1);
        chk("mid_pre_data", 32'(bif.data), 32'h77);
        chk("mid_pre_level", 32'(bif.level), 2);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_dvalid", 32'(bif.dValid), 0);
        chk("mid_rst_data", 32'(bif.data), 0);
        chk("mid_rst_level", 32'(bif.level), 0);
        chk("mid_rst_busy", 32'(bif.busy), 0);
        chk("mid_rst_wr_ready", 32'(bif.wr_ready), 1);
        chk("mid_rst_proto", 32'(bif.proto_err), 0);
        tick();
        tick();
        reset = 1'b1;
        push_word(8'h99);
        tick();
        run_word(8'h99, 1);
        chk("mid_after_level", 32'(bif.level), 0);
        tick();

        // Fill the FIFO while the first word waits, then back-to-back transfers
        push_word(8'h01);
        push_word(8'h02);
        push_word(8'h03);
        push_word(8'h04);
        chk("full_level", 32'(bif.level), 4);
        chk("full_wr_ready", 32'(bif.wr_ready), 0);
        chk("full_head_data", 32'(bif.data), 32'h01);
        bif.wr_valid = 1'b1;
        bif.wr_data  = 8'hEE;
        bif.dAck     = 1'b1;
        tick();
        bif.dAck     = 1'b0;
        bif.wr_valid = 1'b0;
        chk("full_w1_dvalid_lo", 32'(bif.dValid), 0);
        chk("full_w1_done", 32'(bif.xfer_done), 1);
        chk("full_no_push_when_full", 32'(bif.level), 3);
        chk("full_wr_ready_back", 32'(bif.wr_ready), 1);
        for (int w = 2; w <= 4; w++) begin
            tick();
            chk("b2b_dvalid_hi", 32'(bif.dValid), 1);
            chk("b2b_data", 32'(bif.data), 32'(w));
            bif.dAck = 1'b1;
            tick();
            bif.dAck = 1'b0;
            chk("b2b_dvalid_lo", 32'(bif.dValid), 0);
            chk("b2b_done", 32'(bif.xfer_done), 1);
            chk("b2b_level", 32'(bif.level), 32'(4 - w));
        end
        tick();
        chk("b2b_idle_busy", 32'(bif.busy), 0);

        // Simultaneous push and pop at level 2
        push_word(8'h11);
        push_word(8'h22);
        chk("pp_level_before", 32'(bif.level), 2);
        chk("pp_data_11", 32'(bif.data), 32'h11);
        bif.wr_valid = 1'b1;
        bif.wr_data  = 8'h33;
        bif.dAck     = 1'b1;
        tick();
        bif.dAck     = 1'b0;
        bif.wr_valid = 1'b0;
        chk("pp_level_same", 32'(bif.level), 2);
        chk("pp_done", 32'(bif.xfer_done), 1);
        tick();
        chk("pp_data_22", 32'(bif.data), 32'h22);
        bif.dAck = 1'b1;
        tick();
        bif.dAck = 1'b0;
        chk("pp_level_1", 32'(bif.level), 1);
        tick();
        chk("pp_data_33", 32'(bif.data), 32'h33);
        bif.dAck = 1'b1;
        tick();
        bif.dAck = 1'b0;
        chk("pp_level_0", 32'(bif.level), 0);
        chk("pp_proto_clean", 32'(bif.proto_err), 0);
        tick();

        // Protocol checker: ack in IDLE, sticky until reset
        bif.dAck = 1'b1;
        tick();
        bif.dAck = 1'b0;
        chk("pc_idle_ack", 32'(bif.proto_err), 32'(PCHK));
        tick();
        tick();
        chk("pc_sticky", 32'(bif.proto_err), 32'(PCHK));
        reset = 1'b0;
        #1;
        chk("pc_reset_clears", 32'(bif.proto_err), 0);
        tick();
        reset = 1'b1;

        // Protocol checker: ack held for two cycles
        push_word(8'h44);
        tick();
        bif.dAck = 1'b1;
        tick();
        chk("pc_two_ack_done", 32'(bif.xfer_done), 1);
        tick();
        bif.dAck = 1'b0;
        chk("pc_two_ack", 32'(bif.proto_err), 32'(PCHK));
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
